sprite_record_fifo: RTL and testbench
=====================================

Name: sprite_record_fifo

Overview:
- Parametrised successor to the sprite command queue in the SPI driver path.
- Deserialises a byte stream into 6-byte sprite records (id, x, y, scale) and stores them in a circular buffer.
- Presents the head record to the sprite renderer through a valid/ready handshake.
- Adds a synchronised byte strobe, frame-abort on partial records, an almost-full watermark, sticky overflow, flush, and a simultaneous push/pop rule.

Parameters:
- DEPTH, 64, record slots; power of two, ≥4.
- AFULL_LEVEL, DEPTH-4, count at or above which almost_full asserts.
- SYNC_STAGES, 2, flops synchronising data_clk before edge detection (≥2).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- data_clk  in  1  SPI byte strobe, asynchronous to clock; rising edge = new byte.
- enqueue_en  in  1  frame enable from SPI driver; low aborts any partial record.
- enqueue_data  in  8  byte payload.
- flush  in  1  synchronous clear of contents and flags.
- out_ready  in  1  consumer accepts head record.
- out_valid  out  1  head record valid (count>0).
- out_id  out  8  head sprite id.
- out_x  out  16  head x, big-endian assembled.
- out_y  out  16  head y, big-endian assembled.
- out_scale  out  8  head scale.
- count  out  $clog2(DEPTH)+1  stored records, 0..DEPTH.
- almost_full  out  1  count >= AFULL_LEVEL.
- overflow  out  1  sticky: a completed record was dropped while full.

Behaviour:
- Reset (async assert, sync release) and clock domain:
  - Reset clears wr_ptr, rd_ptr, count, byte index, sync chain, overflow and stats.
  - Outputs under reset: out_valid=0, count=0, almost_full=0, overflow=0, out_* = 0. Memory contents are not reset.
  - Byte strobe: data_clk passes through SYNC_STAGES flops, then a registered rising-edge detector. A byte event occurs on the cycle the edge is detected, SYNC_STAGES+1 clocks after the pin rises.
  - enqueue_en and enqueue_data are sampled on the byte-event cycle. The sender holds them stable ≥SYNC_STAGES+2 clocks after the data_clk rise.
- Assembler FSM, byte index 0..5 = ID, XH, XL, YH, YL, SC:
  - Each byte event with enqueue_en=1 writes the staging register field and advances the index.
  - At SC, the record commits on that cycle and the index returns to 0.
  - enqueue_en=0 in any cycle (event or not) forces the index to 0. The staged partial record is discarded.
- Commit:
  - If count<DEPTH, or a pop occurs in the same cycle: write the record to mem[wr_ptr] and increment wr_ptr (wraps modulo DEPTH).
  - Otherwise drop the record and set overflow=1.
  - The committed record becomes visible at the head (out_valid=1, if the FIFO was empty) on the cycle after commit.
- Pop: out_valid && out_ready on a rising clock edge increments rd_ptr (wraps). Head outputs are read combinationally from mem[rd_ptr].
- count:
  - push only: +1; pop only: −1; push and pop in the same cycle: unchanged.
  - No pop when empty. No push when full unless a pop occurs in the same cycle.
- Output rules:
  - almost_full and out_valid are combinational from count.
  - Head data is stable while out_valid=1 and no pop occurs.
- flush:
  - Takes priority over push, pop and an in-flight commit in the same cycle.
  - Clears pointers, count, byte index and overflow on the next edge.
  - A byte event coinciding with flush is discarded.
- Reset mid-record: the partial record is lost and the index restarts at ID.

Optional Feature:
- Macro SPRITE_FIFO_STATS_EN.
- When defined:
  - Adds outputs dropped_records (16 b, saturating at 16'hFFFF) and aborted_frames (16 b, saturating).
  - aborted_frames counts enqueue_en falling while the index is 1..5.
  - Both counters are cleared by reset and flush.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single record: send bytes 0x07,0x01,0x40,0x00,0xF0,0x80 with enqueue_en=1 → out_valid=1, out_id=0x07, out_x=0x0140, out_y=0x00F0, out_scale=0x80, count=1. Pulse out_ready → count=0, out_valid=0.
- Fill to full: push 64 records with ids 0..63 (DEPTH=64) → almost_full once count=60, count=64. Push a 65th record → dropped, overflow=1. Pop all → ids 0..63 in order, pointers wrap.
- Abort: send 3 bytes, drop enqueue_en for 1 cycle, then send 6 bytes id=0x22 → exactly one record, out_id=0x22. With SPRITE_FIFO_STATS_EN defined: aborted_frames=1.
- Simultaneous: with count=64 and out_ready=1, a record completes on the pop cycle → count stays 64, overflow=0, new record stored at the tail.
- Flush during traffic: count=5, a byte event and flush in the same cycle → count=0, overflow=0, index=0. The next 6 bytes form a valid record.
- Async reset asserted mid-record with count=3 → all outputs 0 immediately. After release, a fresh 6-byte record yields count=1.

Source files
------------

// File: rtl/sprite_record_fifo.sv
// sprite_record_fifo: deserialises a strobed byte stream into 6-byte sprite
// records (id, x, y, scale) and queues them in a circular buffer whose head
// is presented to the renderer over a valid/ready handshake.
//
// Handshake: out_valid is high whenever count>0 and is independent of
// out_ready; a record is consumed on a rising clock edge where both
// out_valid and out_ready are high. Head fields are stable while out_valid
// is high and no pop occurs.
//
// Optional feature: define SPRITE_FIFO_STATS_EN to add the saturating
// dropped_records and aborted_frames counters.
//
// dbg_byte_idx exposes the assembler state (byte index) for checkers.
module sprite_record_fifo #(
  parameter int DEPTH       = 64,
  parameter int AFULL_LEVEL = DEPTH - 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     data_clk,
  input  logic                     enqueue_en,
  input  logic [7:0]               enqueue_data,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_id,
  output logic [15:0]              out_x,
  output logic [15:0]              out_y,
  output logic [7:0]               out_scale,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [2:0]               dbg_byte_idx
`ifdef SPRITE_FIFO_STATS_EN
  ,
  output logic [15:0]              dropped_records,
  output logic [15:0]              aborted_frames
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  // Assembler states: index of the next byte expected in the record.
  localparam logic [2:0] IDX_ID = 3'd0;
  localparam logic [2:0] IDX_XH = 3'd1;
  localparam logic [2:0] IDX_XL = 3'd2;
  localparam logic [2:0] IDX_YH = 3'd3;
  localparam logic [2:0] IDX_YL = 3'd4;
  localparam logic [2:0] IDX_SC = 3'd5;

  // Byte strobe synchroniser and edge detector.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   byte_evt_q;

  // Assembler state and staged bytes {id, xh, xl, yh, yl}.
  logic [2:0]  idx_q, idx_d;
  logic [39:0] stage_q, stage_d;
  logic        commit;
  logic [47:0] commit_rec;

  // Queue state.
  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          pop, do_pop, push, drop;
  logic [47:0]   head;

  // Synchronise data_clk, then register the rising-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      byte_evt_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], data_clk};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      byte_evt_q  <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    end
  end

  // Assembler next state: capture bytes on events, commit at the scale byte.
  always_comb begin
    idx_d   = idx_q;
    stage_d = stage_q;
    commit  = 1'b0;
    if (!enqueue_en) begin
      idx_d = IDX_ID;
    end else if (byte_evt_q) begin
      case (idx_q)
        IDX_ID: begin stage_d[39:32] = enqueue_data; idx_d = IDX_XH; end
        IDX_XH: begin stage_d[31:24] = enqueue_data; idx_d = IDX_XL; end
        IDX_XL: begin stage_d[23:16] = enqueue_data; idx_d = IDX_YH; end
        IDX_YH: begin stage_d[15:8]  = enqueue_data; idx_d = IDX_YL; end
        IDX_YL: begin stage_d[7:0]   = enqueue_data; idx_d = IDX_SC; end
        IDX_SC: begin commit = 1'b1;                 idx_d = IDX_ID; end
        default: idx_d = IDX_ID;
      endcase
    end
    if (flush) begin
      idx_d = IDX_ID;
    end
  end

  assign commit_rec = {stage_q, enqueue_data};

  // Push/pop arbitration; flush overrides both.
  always_comb begin
    pop    = out_valid & out_ready;
    do_pop = pop & ~flush;
    push   = commit & ~flush & ((count_q < DEPTH_C) | pop);
    drop   = commit & ~flush & ~push;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Assembler and queue state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q      <= IDX_ID;
      stage_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      stage_q    <= stage_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= commit_rec;
    end
  end

  // Head outputs are zero whenever the queue is empty (including reset).
  assign head        = mem[rd_ptr_q];
  assign out_valid   = (count_q != '0);
  assign out_id      = out_valid ? head[47:40] : 8'h00;
  assign out_x       = out_valid ? head[39:24] : 16'h0000;
  assign out_y       = out_valid ? head[23:8]  : 16'h0000;
  assign out_scale   = out_valid ? head[7:0]   : 8'h00;
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_C);
  assign overflow    = overflow_q;
  assign dbg_byte_idx = idx_q;

`ifdef SPRITE_FIFO_STATS_EN
  logic [15:0] dropped_q;
  logic [15:0] aborted_q;
  logic        abort_evt;

  // A frame abort is enable dropping while a record is partially staged.
  assign abort_evt = ~enqueue_en & (idx_q != IDX_ID);

  // Saturating statistics counters, cleared by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dropped_q <= '0;
      aborted_q <= '0;
    end else if (flush) begin
      dropped_q <= '0;
      aborted_q <= '0;
    end else begin
      if (drop && dropped_q != 16'hFFFF)      dropped_q <= dropped_q + 16'd1;
      if (abort_evt && aborted_q != 16'hFFFF) aborted_q <= aborted_q + 16'd1;
    end
  end

  assign dropped_records = dropped_q;
  assign aborted_frames  = aborted_q;
`endif

endmodule

// File: tb/tb_sprite_record_fifo.sv
// Directed testbench for sprite_record_fifo (DEPTH=64, SYNC_STAGES=2).
module tb_sprite_record_fifo;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        data_clk = 1'b0;
  logic        enqueue_en = 1'b0;
  logic [7:0]  enqueue_data = 8'h00;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_id;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [7:0]  out_scale;
  logic [6:0]  count;
  logic        almost_full;
  logic        overflow;
  logic [2:0]  dbg_byte_idx;
`ifdef SPRITE_FIFO_STATS_EN
  logic [15:0] dropped_records;
  logic [15:0] aborted_frames;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  sprite_record_fifo #(.DEPTH(64), .AFULL_LEVEL(60), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .data_clk(data_clk),
    .enqueue_en(enqueue_en), .enqueue_data(enqueue_data), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_id(out_id),
    .out_x(out_x), .out_y(out_y), .out_scale(out_scale), .count(count),
    .almost_full(almost_full), .overflow(overflow), .dbg_byte_idx(dbg_byte_idx)
`ifdef SPRITE_FIFO_STATS_EN
    , .dropped_records(dropped_records), .aborted_frames(aborted_frames)
`endif
  );

  // Clock
  always #5 clock = ~clock;

  // Driver: one byte strobe. Optionally pops or flushes in the byte-event
  // cycle (third cycle after the rise: two sync flops + edge register).
  task automatic send_byte(input logic [7:0] b, input bit pop_evt, input bit flush_evt);
    enqueue_data = b;
    enqueue_en   = 1'b1;
    data_clk     = 1'b1;
    repeat (3) @(negedge clock);
    if (pop_evt)   out_ready = 1'b1;
    if (flush_evt) flush = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clock);
    data_clk = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic send_record(input logic [7:0] id, input logic [15:0] x,
                             input logic [15:0] y, input logic [7:0] sc);
    send_byte(id, 1'b0, 1'b0);
    send_byte(x[15:8], 1'b0, 1'b0);
    send_byte(x[7:0], 1'b0, 1'b0);
    send_byte(y[15:8], 1'b0, 1'b0);
    send_byte(y[7:0], 1'b0, 1'b0);
    send_byte(sc, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic fill_ids(input int n);
    for (int i = 0; i < n; i++) begin
      send_record(8'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i), 8'(i) ^ 8'hFF);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
    tests_run++; if (count !== 7'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
    tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL reset_afull: got %0h want 0", almost_full); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0h want 0", overflow); end
    tests_run++; if ({out_id, out_x, out_y, out_scale} !== 48'h0) begin tests_failed++; $display("FAIL reset_data: got %0h want 0", {out_id, out_x, out_y, out_scale}); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++; if (dbg_byte_idx !== 3'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d want 0", dbg_byte_idx); end
  endtask

  task automatic test_single_record();
    send_record(8'h07, 16'h0140, 16'h00F0, 8'h80);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %0h want 1", out_valid); end
    tests_run++; if (out_id !== 8'h07) begin tests_failed++; $display("FAIL single_id: got %0h want 07", out_id); end
    tests_run++; if (out_x !== 16'h0140) begin tests_failed++; $display("FAIL single_x: got %0h want 0140", out_x); end
    tests_run++; if (out_y !== 16'h00F0) begin tests_failed++; $display("FAIL single_y: got %0h want 00f0", out_y); end
    tests_run++; if (out_scale !== 8'h80) begin tests_failed++; $display("FAIL single_scale: got %0h want 80", out_scale); end
    tests_run++; if (count !== 7'd1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", count); end
    pop_one();
    tests_run++; if (count !== 7'd0) begin tests_failed++; $display("FAIL single_pop_count: got %0d want 0", count); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_pop_valid: got %0h want 0", out_valid); end
  endtask

  task automatic test_abort();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h13, 1'b0, 1'b0);
    tests_run++; if (dbg_byte_idx !== 3'd3) begin tests_failed++; $display("FAIL abort_idx_pre: got %0d want 3", dbg_byte_idx); end
    enqueue_en = 1'b0;
    @(negedge clock);
    enqueue_en = 1'b1;
    tests_run++; if (dbg_byte_idx !== 3'd0) begin tests_failed++; $display("FAIL abort_idx_post: got %0d want 0", dbg_byte_idx); end
    send_record(8'h22, 16'h1234, 16'h5678, 8'h9A);
    tests_run++; if (count !== 7'd1) begin tests_failed++; $display("FAIL abort_count: got %0d want 1", count); end
    tests_run++; if (out_id !== 8'h22) begin tests_failed++; $display("FAIL abort_id: got %0h want 22", out_id); end
    tests_run++; if (out_x !== 16'h1234) begin tests_failed++; $display("FAIL abort_x: got %0h want 1234", out_x); end
`ifdef SPRITE_FIFO_STATS_EN
    tests_run++; if (aborted_frames !== 16'd1) begin tests_failed++; $display("FAIL abort_stat: got %0d want 1", aborted_frames); end
`endif
    pop_one();
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 64; i++) begin
      send_record(8'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i), 8'(i) ^ 8'hFF);
      tests_run++; if (count !== 7'(i + 1)) begin tests_failed++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
      tests_run++; if (almost_full !== ((i + 1) >= 60)) begin tests_failed++; $display("FAIL fill_afull[%0d]: got %0h want %0h", i, almost_full, ((i + 1) >= 60)); end
    end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_ovf_pre: got %0h want 0", overflow); end
    send_record(8'hAA, 16'hAAAA, 16'hAAAA, 8'hAA);
    tests_run++; if (count !== 7'd64) begin tests_failed++; $display("FAIL full_drop_count: got %0d want 64", count); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL full_drop_ovf: got %0h want 1", overflow); end
`ifdef SPRITE_FIFO_STATS_EN
    tests_run++; if (dropped_records !== 16'd1) begin tests_failed++; $display("FAIL full_drop_stat: got %0d want 1", dropped_records); end
`endif
    for (int i = 0; i < 64; i++) begin
      tests_run++; if (out_id !== 8'(i)) begin tests_failed++; $display("FAIL drain_id[%0d]: got %0h want %0h", i, out_id, 8'(i)); end
      tests_run++; if (out_y !== 16'h0200 + 16'(i)) begin tests_failed++; $display("FAIL drain_y[%0d]: got %0h want %0h", i, out_y, 16'h0200 + 16'(i)); end
      pop_one();
    end
    tests_run++; if (count !== 7'd0) begin tests_failed++; $display("FAIL drain_count: got %0d want 0", count); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_valid: got %0h want 0", out_valid); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %0h want 1", overflow); end
    do_flush();
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL flush_ovf: got %0h want 0", overflow); end
  endtask

  task automatic test_simultaneous();
    fill_ids(64);
    tests_run++; if (count !== 7'd64) begin tests_failed++; $display("FAIL simul_pre_count: got %0d want 64", count); end
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h0A, 1'b0, 1'b0);
    send_byte(8'h0B, 1'b0, 1'b0);
    send_byte(8'h0C, 1'b0, 1'b0);
    send_byte(8'h0D, 1'b0, 1'b0);
    send_byte(8'h0E, 1'b1, 1'b0);
    tests_run++; if (count !== 7'd64) begin tests_failed++; $display("FAIL simul_count: got %0d want 64", count); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL simul_ovf: got %0h want 0", overflow); end
    for (int i = 1; i < 64; i++) begin
      tests_run++; if (out_id !== 8'(i)) begin tests_failed++; $display("FAIL simul_drain[%0d]: got %0h want %0h", i, out_id, 8'(i)); end
      pop_one();
    end
    tests_run++; if (out_id !== 8'h55) begin tests_failed++; $display("FAIL simul_tail_id: got %0h want 55", out_id); end
    tests_run++; if ({out_x, out_y, out_scale} !== 40'h0A0B0C0D0E) begin tests_failed++; $display("FAIL simul_tail_data: got %0h want 0a0b0c0d0e", {out_x, out_y, out_scale}); end
    pop_one();
    tests_run++; if (count !== 7'd0) begin tests_failed++; $display("FAIL simul_end_count: got %0d want 0", count); end
  endtask

  task automatic test_flush_traffic();
    fill_ids(5);
    tests_run++; if (count !== 7'd5) begin tests_failed++; $display("FAIL flush_pre_count: got %0d want 5", count); end
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0);
    send_byte(8'h63, 1'b0, 1'b0);
    send_byte(8'h64, 1'b0, 1'b0);
    send_byte(8'h65, 1'b0, 1'b0);
    send_byte(8'h66, 1'b0, 1'b1);
    tests_run++; if (count !== 7'd0) begin tests_failed++; $display("FAIL flush_count: got %0d want 0", count); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL flush_ovf2: got %0h want 0", overflow); end
    tests_run++; if (dbg_byte_idx !== 3'd0) begin tests_failed++; $display("FAIL flush_idx: got %0d want 0", dbg_byte_idx); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %0h want 0", out_valid); end
    send_record(8'h33, 16'hBEEF, 16'hCAFE, 8'h01);
    tests_run++; if (count !== 7'd1) begin tests_failed++; $display("FAIL flush_next_count: got %0d want 1", count); end
    tests_run++; if (out_id !== 8'h33) begin tests_failed++; $display("FAIL flush_next_id: got %0h want 33", out_id); end
    tests_run++; if (out_y !== 16'hCAFE) begin tests_failed++; $display("FAIL flush_next_y: got %0h want cafe", out_y); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    fill_ids(3);
    tests_run++; if (count !== 7'd3) begin tests_failed++; $display("FAIL rmid_pre_count: got %0d want 3", count); end
    send_byte(8'h71, 1'b0, 1'b0);
    send_byte(8'h72, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++; if (count !== 7'd0) begin tests_failed++; $display("FAIL rmid_count: got %0d want 0", count); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid: got %0h want 0", out_valid); end
    tests_run++; if ({out_id, out_x, out_y, out_scale} !== 48'h0) begin tests_failed++; $display("FAIL rmid_data: got %0h want 0", {out_id, out_x, out_y, out_scale}); end
    tests_run++; if (dbg_byte_idx !== 3'd0) begin tests_failed++; $display("FAIL rmid_idx: got %0d want 0", dbg_byte_idx); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send_record(8'h44, 16'h0001, 16'h0002, 8'h03);
    tests_run++; if (count !== 7'd1) begin tests_failed++; $display("FAIL rmid_after_count: got %0d want 1", count); end
    tests_run++; if (out_id !== 8'h44) begin tests_failed++; $display("FAIL rmid_after_id: got %0h want 44", out_id); end
  endtask

  initial begin
    test_reset();
    test_single_record();
    test_abort();
    test_fill_full();
    test_simultaneous();
    test_flush_traffic();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
